// File: rtl/chan_sched_pkg.sv
// Shared types and width helpers for the round-robin channel scheduler.
package chan_sched_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StXfer = 1'b1
  } state_e;

  // Index width for n channels; never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $unsigned($clog2(n)) : 1;
  endfunction

  // Burst counter width able to hold 0..max_burst.
  function automatic int unsigned cnt_width(input int unsigned max_burst);
    return $unsigned($clog2(max_burst + 1));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after `last`,
// wrapping N-1 -> 0, built as a double-width rotate plus priority encode.
module rr_pick
  import chan_sched_pkg::*;
#(
  parameter int unsigned N  = 70,
  parameter int unsigned IW = ch_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] NumCh = (IW + 1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    shamt;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  always_comb begin
    dbl   = {req, req};
    shamt = {1'b0, last} + 1'b1;
    // rot[i] is the request of channel (last + 1 + i) mod N
    rot   = dbl[shamt +: N];
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IW'(i);
      end
    end
    sum = {1'b0, last} + {1'b0, off} + 1'b1;
    idx = (sum >= NumCh) ? IW'(sum - NumCh) : IW'(sum);
    any = |req;
  end

endmodule

// File: rtl/chan_rr_scheduler.sv
// Round-robin scheduler: grants one requester at a time for up to MAX_BURST words and
// registers the winning word, tagged with its channel, onto the datapath input bus.
module chan_rr_scheduler
  import chan_sched_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CHANNEL   = 70,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned CH_W     = ch_width(CHANNEL)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNEL-1:0]         req_valid,
  input  logic [CHANNEL*WIDTH-1:0]   req_data,
  output logic [CHANNEL-1:0]         req_ready,
  input  logic                       dp_stall,
  output logic [WIDTH-1:0]           dp_in,
  output logic                       dp_valid,
  output logic [CH_W-1:0]            dp_ch,
  output logic                       busy
);

  localparam int unsigned CNT_W = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(MAX_BURST - 1);
  localparam logic [CH_W-1:0]  LastCh   = CH_W'(CHANNEL - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  dp_in_q, dp_in_d;
  logic              dp_valid_q, dp_valid_d;
  logic [CH_W-1:0]   dp_ch_q, dp_ch_d;

  logic              pick_any;
  logic [CH_W-1:0]   pick_idx;
  logic [WIDTH-1:0]  lane [CHANNEL];
  logic [WIDTH-1:0]  grant_data;
  logic              grant_valid;
  logic              xfer;

  rr_pick #(
    .N  (CHANNEL),
    .IW (CH_W)
  ) u_pick (
    .req  (req_valid),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    for (int c = 0; c < CHANNEL; c++) begin
      lane[c] = req_data[c*WIDTH +: WIDTH];
    end
  end

  assign grant_data  = lane[grant_q];
  assign grant_valid = req_valid[grant_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    dp_in_d    = dp_in_q;
    dp_valid_d = dp_valid_q;
    dp_ch_d    = dp_ch_q;
    req_ready  = '0;
    xfer       = (state_q == StXfer) && grant_valid && !dp_stall;

    if (state_q == StXfer) begin
      req_ready[grant_q] = ~dp_stall;
    end
    // A stall freezes the output word; otherwise valid tracks this cycle's transfer.
    if (!dp_stall) begin
      dp_valid_d = xfer;
    end

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (xfer) begin
          dp_in_d = grant_data;
          dp_ch_d = grant_q;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            state_d = StIdle;
            last_d  = grant_q;
          end
        end else if (!dp_stall && !grant_valid) begin
          state_d = StIdle;
          last_d  = grant_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      last_q     <= LastCh;
      cnt_q      <= '0;
      dp_in_q    <= '0;
      dp_valid_q <= 1'b0;
      dp_ch_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      dp_in_q    <= dp_in_d;
      dp_valid_q <= dp_valid_d;
      dp_ch_q    <= dp_ch_d;
    end
  end

  assign dp_in    = dp_in_q;
  assign dp_valid = dp_valid_q;
  assign dp_ch    = dp_ch_q;
  assign busy     = (state_q == StXfer);

endmodule

// File: doc/chan_rr_scheduler.md
# chan_rr_scheduler

Round-robin scheduler that shares the single `WIDTH`-bit datapath input bus of a random-design top (`in`, `CHANNEL` lanes) among `CHANNEL` independent requesters. Each requester offers words over a valid/ready handshake. The block grants one channel at a time for a bounded burst and registers the winning word onto the datapath bus, tagged with its channel index. It sits between stimulus/producer logic and the datapath top and honours a back-pressure stall from the datapath.

## Interface
- `WIDTH`, 32, datapath word width
- `CHANNEL`, 70, number of requesters (>= 2)
- `MAX_BURST`, 4, max words per grant (>= 1)
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  asynchronous, active-low reset
- `req_valid`  input  CHANNEL  per-channel word valid
- `req_data`  input  CHANNEL*WIDTH  channel c word at bits [c*WIDTH +: WIDTH]
- `req_ready`  output  CHANNEL  per-channel accept; at most one bit high
- `dp_stall`  input  1  datapath back-pressure
- `dp_in`  output  WIDTH  registered word to the datapath `in`
- `dp_valid`  output  1  `dp_in` holds a new word
- `dp_ch`  output  CH_W  channel of `dp_in`; CH_W = $clog2(CHANNEL)
- `busy`  output  1  high while in state XFER

## Operation
- States:
  - IDLE: no grant.
    - If any `req_valid` bit is high, pick the first asserted channel after `last_grant` (wrapping CHANNEL-1 -> 0).
    - Register it as `grant`, clear `burst_cnt`, go to XFER.
  - XFER: `req_ready[grant] = !dp_stall`; all other ready bits are 0.
    - A transfer occurs when `req_valid[grant] && req_ready[grant]`.
    - On a transfer: `dp_in <= req_data[grant]`, `dp_ch <= grant`, `dp_valid <= 1`, `burst_cnt++`.
- Leave XFER for IDLE, and set `last_grant <= grant`, when:
  - a transfer makes `burst_cnt` equal `MAX_BURST`, or
  - `req_valid[grant]` is low while `dp_stall` is low (requester ran dry).
- `dp_stall` high: `dp_in`, `dp_valid`, `dp_ch` hold their values, `burst_cnt` holds, and the state stays XFER. A stall does not end a burst.
- `dp_valid` behaviour:
  - Without stall, `dp_valid` deasserts on any cycle with no transfer.
  - In IDLE, `dp_valid` is 0 once any pending stall clears.
- Fairness: with all channels valid, grants cycle 0, 1, …, CHANNEL-1, 0, … with MAX_BURST words each.
- Simultaneous events:
  - Final-burst transfer plus other channels valid: the next grant goes to the next channel after the current one. IDLE always occupies one cycle.
  - `req_valid` drop plus `dp_stall` high: stay in XFER. The exit is evaluated after the stall clears.
- Reset (any time, including mid-burst):
  - `dp_in`=0, `dp_valid`=0, `dp_ch`=0, `req_ready`=0, `busy`=0.
  - state=IDLE, `grant`=0, `burst_cnt`=0, `last_grant`=CHANNEL-1, so channel 0 wins first.
  - No partial word is emitted after reset release.

## Timing
- `req_valid[c]` rises at edge t in IDLE → grant registered at t+1. `req_ready[c]` is high during cycle t+1.
- First transfer occurs at edge t+2, giving `dp_valid`=1 and `dp_in` after t+2. Total latency from valid to data is 2 cycles.
- Subsequent words of a burst stream one per cycle.
- Inter-burst gap: 1 IDLE cycle.
- `req_ready` is combinational from state, `grant` and `dp_stall` only. It never depends on `req_valid`.
- All other outputs are registered.
- Minimum channel switch period: MAX_BURST+1 cycles.

## Structure
- Package `chan_sched_pkg`:
  - state enum {IDLE, XFER}
  - `CH_W` / burst-counter width helper functions, e.g. $clog2(MAX_BURST+1)
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector, `last` index.
  - Outputs: `any`, `idx`.
  - Implemented as a double-width rotate plus priority encode.
- Top holds the FSM, counters and output registers.

## Test plan
- Reset: assert `rst`=0 mid-burst on channel 5 → all outputs 0 within the same cycle, asynchronously. After release, channel 0 is granted first when all channels are valid.
- Single channel: only ch 3 valid, `req_data`=32'habcdefab for 6 words → `dp_valid` 2 cycles after valid, 4 words with `dp_ch`=3, 1 IDLE cycle, then 2 more words.
- Full contention: all 70 channels valid with data = channel index → `dp_ch` sequence 0×4, 1×4, … 69×4, 0×4. Check one IDLE gap between bursts.
- Stall: `dp_stall`=1 for 3 cycles mid-burst on ch 7 (word 32'h12345678) → `dp_in`, `dp_valid`, `dp_ch` frozen and `req_ready`=0. The burst resumes and completes 4 words total.
- Early drop: ch 2 valid for 2 words (32'haaaaaaaa) then low → return to IDLE; the next grant goes to ch 3 if valid, not ch 2.
- Wrap: only ch 69 and ch 0 valid → grants alternate 69, 0, 69.
